// File: rtl/meter_pkg.sv
// Shared encodings and BCD helpers for the parking meter command scheduler.
package meter_pkg;

  typedef enum logic [1:0] {
    OP_NOP = 2'd0,
    OP_ADD = 2'd1,
    OP_SET = 2'd2,
    OP_DEC = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    MODE_INIT     = 2'd0,
    MODE_RUN_HIGH = 2'd1,
    MODE_RUN_LOW  = 2'd2,
    MODE_EXPIRED  = 2'd3
  } mode_t;

  localparam logic [15:0] AMT_60  = 16'h0060;
  localparam logic [15:0] AMT_120 = 16'h0120;
  localparam logic [15:0] AMT_180 = 16'h0180;
  localparam logic [15:0] AMT_300 = 16'h0300;
  localparam logic [15:0] AMT_DEC = 16'h0001;

  // Request indices double as priority: a lower index wins.
  localparam int NUM_REQ    = 7;
  localparam int REQ_SET150 = 0;
  localparam int REQ_SET16  = 1;
  localparam int REQ_DEC    = 2;
  localparam int REQ_ADD300 = 3;
  localparam int REQ_ADD180 = 4;
  localparam int REQ_ADD120 = 5;
  localparam int REQ_ADD60  = 6;
  localparam logic [NUM_REQ-1:0] ADD_REQ_MASK = 7'b111_1000;

  function automatic logic bcd_lt(input logic [15:0] a, input logic [15:0] b);
    logic decided;
    logic lt;
    decided = 1'b0;
    lt      = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (!decided && (a[i*4 +: 4] != b[i*4 +: 4])) begin
        lt      = (a[i*4 +: 4] < b[i*4 +: 4]);
        decided = 1'b1;
      end
    end
    return lt;
  endfunction

  function automatic logic bcd_invalid(input logic [15:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (v[i*4 +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

endpackage

// File: rtl/meter_req_arbiter.sv
// Button edge detection, sticky pending requests and fixed-priority one-hot grant.
module meter_req_arbiter
  import meter_pkg::*;
(
  input  logic               clock,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] i_btn,
  input  logic               i_decSet,
  input  logic [NUM_REQ-1:0] i_clr,
  input  logic               i_selEn,
  output logic [NUM_REQ-1:0] o_grant,
  output logic               o_pendDec
);

  logic [NUM_REQ-1:0] r_prev;
  logic [NUM_REQ-1:0] r_pend;
  logic [NUM_REQ-1:0] w_set;
  logic [NUM_REQ-1:0] w_avail;

  // New requests win over the accept-clear, so a press landing on the accept edge survives.
  always_comb begin
    w_set          = i_btn & ~r_prev;
    w_set[REQ_DEC] = i_decSet;
    w_avail        = r_pend & ~i_clr;
    o_grant        = '0;
    if (i_selEn) o_grant = w_avail & (~w_avail + {{(NUM_REQ-1){1'b0}}, 1'b1});
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      r_prev <= '1;
      r_pend <= '0;
    end else begin
      r_prev <= i_btn;
      r_pend <= w_avail | w_set;
    end
  end

  assign o_pendDec = r_pend[REQ_DEC];

endmodule

// File: rtl/meter_cmd_scheduler.sv
// Serializes button and tick requests into one valid/ready command stream and tracks meter mode.
module meter_cmd_scheduler
  import meter_pkg::*;
#(
  parameter logic [15:0] THRESH_BCD = 16'h0180,
  parameter logic [15:0] SET_A_BCD  = 16'h0016,
  parameter logic [15:0] SET_B_BCD  = 16'h0150
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        i_btn_add60,
  input  logic        i_btn_add120,
  input  logic        i_btn_add180,
  input  logic        i_btn_add300,
  input  logic        i_btn_set16,
  input  logic        i_btn_set150,
  input  logic        i_tick_1s,
  input  logic [15:0] i_time_bcd,
  input  logic        i_cmd_ready,
  output logic        o_cmd_valid,
  output logic [1:0]  o_cmd_op,
  output logic [15:0] o_cmd_amount,
  output logic [1:0]  o_mode,
  output logic        o_tick_overrun,
  output logic        o_bcd_err
);

  logic               r_cmdValid;
  op_t                r_cmdOp;
  logic [15:0]        r_cmdAmount;
  logic [NUM_REQ-1:0] r_cmdSrc;
  mode_t              r_mode;
  logic               r_initArm;
  logic               r_overrun;
  logic               r_bcdErr;

  logic [NUM_REQ-1:0] w_btn;
  logic [NUM_REQ-1:0] w_grant;
  logic [NUM_REQ-1:0] w_clr;
  logic               w_accept;
  logic               w_selEn;
  logic               w_bcdBad;
  logic               w_timeZero;
  logic               w_belowThresh;
  logic               w_decSet;
  logic               w_pendDec;
  op_t                w_nextOp;
  logic [15:0]        w_nextAmt;

  assign w_accept      = r_cmdValid & i_cmd_ready;
  assign w_selEn       = ~r_cmdValid | w_accept;
  assign w_bcdBad      = bcd_invalid(i_time_bcd);
  assign w_timeZero    = (i_time_bcd == 16'h0000);
  assign w_belowThresh = bcd_lt(i_time_bcd, THRESH_BCD);
  assign w_decSet      = i_tick_1s & ~w_timeZero & ~w_bcdBad;

  always_comb begin
    w_btn             = '0;
    w_btn[REQ_SET150] = i_btn_set150;
    w_btn[REQ_SET16]  = i_btn_set16;
    w_btn[REQ_ADD300] = i_btn_add300;
    w_btn[REQ_ADD180] = i_btn_add180;
    w_btn[REQ_ADD120] = i_btn_add120;
    w_btn[REQ_ADD60]  = i_btn_add60;
  end

  // An accepted SET supersedes any queued ADDs; a queued DEC is kept.
  always_comb begin
    w_clr = '0;
    if (w_accept) begin
      w_clr = r_cmdSrc;
      if (r_cmdOp == OP_SET) w_clr = w_clr | ADD_REQ_MASK;
    end
  end

  meter_req_arbiter u_arbiter (
    .clock     (clock),
    .rst       (rst),
    .i_btn     (w_btn),
    .i_decSet  (w_decSet),
    .i_clr     (w_clr),
    .i_selEn   (w_selEn),
    .o_grant   (w_grant),
    .o_pendDec (w_pendDec)
  );

  always_comb begin
    w_nextOp  = OP_NOP;
    w_nextAmt = 16'h0000;
    if (w_grant[REQ_SET150]) begin
      w_nextOp  = OP_SET;
      w_nextAmt = SET_B_BCD;
    end else if (w_grant[REQ_SET16]) begin
      w_nextOp  = OP_SET;
      w_nextAmt = SET_A_BCD;
    end else if (w_grant[REQ_DEC]) begin
      w_nextOp  = OP_DEC;
      w_nextAmt = AMT_DEC;
    end else if (w_grant[REQ_ADD300]) begin
      w_nextOp  = OP_ADD;
      w_nextAmt = AMT_300;
    end else if (w_grant[REQ_ADD180]) begin
      w_nextOp  = OP_ADD;
      w_nextAmt = AMT_180;
    end else if (w_grant[REQ_ADD120]) begin
      w_nextOp  = OP_ADD;
      w_nextAmt = AMT_120;
    end else if (w_grant[REQ_ADD60]) begin
      w_nextOp  = OP_ADD;
      w_nextAmt = AMT_60;
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      r_cmdValid  <= 1'b0;
      r_cmdOp     <= OP_NOP;
      r_cmdAmount <= 16'h0000;
      r_cmdSrc    <= '0;
    end else if (w_selEn) begin
      r_cmdValid  <= |w_grant;
      r_cmdOp     <= w_nextOp;
      r_cmdAmount <= w_nextAmt;
      r_cmdSrc    <= w_grant;
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      r_overrun <= 1'b0;
      r_bcdErr  <= 1'b0;
    end else begin
      if (w_bcdBad) r_bcdErr <= 1'b1;
      if (i_tick_1s & w_pendDec & ~w_clr[REQ_DEC]) r_overrun <= 1'b1;
    end
  end

  // Leaving INIT waits one cycle so the datapath's updated value decides HIGH vs LOW.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_mode    <= MODE_INIT;
      r_initArm <= 1'b0;
    end else begin
      if ((r_mode == MODE_INIT) && w_accept && ((r_cmdOp == OP_ADD) || (r_cmdOp == OP_SET)))
        r_initArm <= 1'b1;
      if (!w_bcdBad) begin
        case (r_mode)
          MODE_INIT: begin
            if (r_initArm) begin
              r_mode    <= w_belowThresh ? MODE_RUN_LOW : MODE_RUN_HIGH;
              r_initArm <= 1'b0;
            end
          end
          MODE_RUN_HIGH: begin
            if (w_timeZero)         r_mode <= MODE_EXPIRED;
            else if (w_belowThresh) r_mode <= MODE_RUN_LOW;
          end
          MODE_RUN_LOW: begin
            if (w_timeZero)          r_mode <= MODE_EXPIRED;
            else if (!w_belowThresh) r_mode <= MODE_RUN_HIGH;
          end
          default: begin
            if (!w_timeZero) r_mode <= w_belowThresh ? MODE_RUN_LOW : MODE_RUN_HIGH;
          end
        endcase
      end
    end
  end

  assign o_cmd_valid    = r_cmdValid;
  assign o_cmd_op       = r_cmdOp;
  assign o_cmd_amount   = r_cmdAmount;
  assign o_mode         = r_mode;
  assign o_tick_overrun = r_overrun;
  assign o_bcd_err      = r_bcdErr;

endmodule

// File: tb/tb_meter_cmd_scheduler.sv
// Scoreboard bench for meter_cmd_scheduler: expected commands are queued as stimulus is driven.
module tb_meter_cmd_scheduler;

  localparam logic [5:0] B_ADD60  = 6'b000001;
  localparam logic [5:0] B_ADD120 = 6'b000010;
  localparam logic [5:0] B_ADD180 = 6'b000100;
  localparam logic [5:0] B_ADD300 = 6'b001000;
  localparam logic [5:0] B_SET16  = 6'b010000;
  localparam logic [5:0] B_SET150 = 6'b100000;
  localparam logic [1:0] E_ADD = 2'd1, E_SET = 2'd2, E_DEC = 2'd3;

  logic        clock = 1'b0;
  logic        rst;
  logic        add60, add120, add180, add300, set16, set150;
  logic        tick1s;
  logic [15:0] timeBcd;
  logic        cmdReady;
  logic        cmdValid;
  logic [1:0]  cmdOp;
  logic [15:0] cmdAmount;
  logic [1:0]  mode;
  logic        tickOverrun;
  logic        bcdErr;

  logic [17:0] expQ[$];
  int          nChecks = 0;
  int          nBad = 0;

  always #5 clock = ~clock;

  meter_cmd_scheduler dut (
    .clock          (clock),
    .rst            (rst),
    .i_btn_add60    (add60),
    .i_btn_add120   (add120),
    .i_btn_add180   (add180),
    .i_btn_add300   (add300),
    .i_btn_set16    (set16),
    .i_btn_set150   (set150),
    .i_tick_1s      (tick1s),
    .i_time_bcd     (timeBcd),
    .i_cmd_ready    (cmdReady),
    .o_cmd_valid    (cmdValid),
    .o_cmd_op       (cmdOp),
    .o_cmd_amount   (cmdAmount),
    .o_mode         (mode),
    .o_tick_overrun (tickOverrun),
    .o_bcd_err      (bcdErr)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nBad++;
      $display("[TB] FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drives one cycle of inputs, then returns 1 time unit after the next rising edge.
  task automatic applyStimulus(input logic [5:0] btns, input logic tick, input logic rdy,
                               input logic [15:0] tbcd);
    {set150, set16, add300, add180, add120, add60} = btns;
    tick1s   = tick;
    cmdReady = rdy;
    timeBcd  = tbcd;
    @(posedge clock);
    #1;
  endtask

  // Every handshake that will complete on the next edge is matched against the queue.
  always @(negedge clock) begin : monitor
    logic [17:0] e;
    if (!rst && cmdValid && cmdReady) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_cmd", 32'({cmdOp, cmdAmount}), 32'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("cmd", 32'({cmdOp, cmdAmount}), 32'(e));
      end
    end
  end

  initial begin
    rst = 1'b1;
    {set150, set16, add300, add180, add120, add60} = B_ADD60;
    tick1s   = 1'b0;
    cmdReady = 1'b1;
    timeBcd  = 16'h0000;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("rst_valid", 32'(cmdValid), 32'd0);
    checkOutput("rst_op_amt", 32'({cmdOp, cmdAmount}), 32'd0);
    checkOutput("rst_mode", 32'(mode), 32'd0);
    checkOutput("rst_flags", 32'({tickOverrun, bcdErr}), 32'd0);

    // Button held through reset never fires; a fresh press yields exactly one ADD 60.
    rst = 1'b0;
    repeat (3) applyStimulus(B_ADD60, 1'b0, 1'b1, 16'h0000);
    checkOutput("held_no_fire", 32'(cmdValid), 32'd0);
    applyStimulus(6'b0, 1'b0, 1'b1, 16'h0000);
    expQ.push_back({E_ADD, 16'h0060});
    applyStimulus(B_ADD60, 1'b0, 1'b1, 16'h0000);
    checkOutput("lat_pending_edge", 32'(cmdValid), 32'd0);
    applyStimulus(B_ADD60, 1'b0, 1'b1, 16'h0000);
    checkOutput("lat_valid_next", 32'({cmdValid, cmdOp, cmdAmount}), 32'({1'b1, E_ADD, 16'h0060}));
    applyStimulus(6'b0, 1'b0, 1'b1, 16'h0000);
    checkOutput("add60_one_shot", 32'(cmdValid), 32'd0);
    applyStimulus(6'b0, 1'b0, 1'b1, 16'h0060);
    checkOutput("init_to_low", 32'(mode), 32'd2);

    // SET150 and ADD300 together: only the SET survives, INIT -> RUN_LOW.
    rst = 1'b1;
    applyStimulus(6'b0, 1'b0, 1'b1, 16'h0000);
    applyStimulus(6'b0, 1'b0, 1'b1, 16'h0000);
    rst = 1'b0;
    applyStimulus(6'b0, 1'b0, 1'b1, 16'h0000);
    expQ.push_back({E_SET, 16'h0150});
    applyStimulus(B_SET150 | B_ADD300, 1'b0, 1'b1, 16'h0000);
    applyStimulus(B_SET150 | B_ADD300, 1'b0, 1'b1, 16'h0000);
    checkOutput("set150_first", 32'({cmdValid, cmdOp, cmdAmount}), 32'({1'b1, E_SET, 16'h0150}));
    applyStimulus(6'b0, 1'b0, 1'b1, 16'h0000);
    checkOutput("add_dropped", 32'(cmdValid), 32'd0);
    applyStimulus(6'b0, 1'b0, 1'b1, 16'h0150);
    checkOutput("set_init_to_low", 32'(mode), 32'd2);
    applyStimulus(6'b0, 1'b0, 1'b1, 16'h0150);
    checkOutput("add_still_dropped", 32'(cmdValid), 32'd0);

    // Backpressure: ADD 120 held stable for five stalled cycles.
    expQ.push_back({E_ADD, 16'h0120});
    applyStimulus(B_ADD120, 1'b0, 1'b0, 16'h0150);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(6'b0, 1'b0, 1'b0, 16'h0150);
      checkOutput($sformatf("stall_hold%0d", i), 32'({cmdValid, cmdOp, cmdAmount}),
                  32'({1'b1, E_ADD, 16'h0120}));
    end
    applyStimulus(6'b0, 1'b0, 1'b1, 16'h0150);
    checkOutput("drop_after_accept", 32'(cmdValid), 32'd0);
    applyStimulus(6'b0, 1'b0, 1'b1, 16'h0270);
    checkOutput("low_to_high", 32'(mode), 32'd1);

    // Tick at threshold, datapath then returns 0179: RUN_HIGH -> RUN_LOW.
    applyStimulus(6'b0, 1'b0, 1'b1, 16'h0180);
    expQ.push_back({E_DEC, 16'h0001});
    applyStimulus(6'b0, 1'b1, 1'b1, 16'h0180);
    applyStimulus(6'b0, 1'b0, 1'b1, 16'h0180);
    checkOutput("dec_issued", 32'({cmdValid, cmdOp, cmdAmount}), 32'({1'b1, E_DEC, 16'h0001}));
    applyStimulus(6'b0, 1'b0, 1'b1, 16'h0180);
    checkOutput("high_at_thresh", 32'(mode), 32'd1);
    applyStimulus(6'b0, 1'b0, 1'b1, 16'h0179);
    checkOutput("high_to_low", 32'(mode), 32'd2);

    // Two ticks while stalled: one DEC, sticky overrun.
    expQ.push_back({E_DEC, 16'h0001});
    applyStimulus(6'b0, 1'b1, 1'b0, 16'h0179);
    applyStimulus(6'b0, 1'b0, 1'b0, 16'h0179);
    checkOutput("overrun_before", 32'(tickOverrun), 32'd0);
    applyStimulus(6'b0, 1'b1, 1'b0, 16'h0179);
    checkOutput("overrun_set", 32'(tickOverrun), 32'd1);
    applyStimulus(6'b0, 1'b0, 1'b1, 16'h0179);
    checkOutput("single_dec", 32'(cmdValid), 32'd0);
    repeat (3) applyStimulus(6'b0, 1'b0, 1'b1, 16'h0179);
    checkOutput("overrun_sticky", 32'({cmdValid, tickOverrun}), 32'b01);

    // Zero time: ticks discarded, EXPIRED; invalid nibble freezes mode.
    applyStimulus(6'b0, 1'b0, 1'b1, 16'h0000);
    checkOutput("to_expired", 32'(mode), 32'd3);
    for (int i = 0; i < 4; i++) applyStimulus(6'b0, (i % 2 == 0), 1'b1, 16'h0000);
    checkOutput("no_dec_at_zero", 32'(cmdValid), 32'd0);
    applyStimulus(6'b0, 1'b0, 1'b1, 16'h00A0);
    checkOutput("bcd_err_set", 32'({bcdErr, mode}), 32'({1'b1, 2'd3}));
    applyStimulus(6'b0, 1'b1, 1'b1, 16'h00A0);
    applyStimulus(6'b0, 1'b0, 1'b1, 16'h00A0);
    checkOutput("no_dec_bad_bcd", 32'({cmdValid, mode}), 32'({1'b0, 2'd3}));
    applyStimulus(6'b0, 1'b0, 1'b1, 16'h0000);
    checkOutput("bcd_err_sticky", 32'(bcdErr), 32'd1);

    // Reset while a command is presented: it is dropped and never accepted.
    applyStimulus(B_ADD180, 1'b0, 1'b0, 16'h0000);
    applyStimulus(6'b0, 1'b0, 1'b0, 16'h0000);
    checkOutput("pre_rst_valid", 32'({cmdValid, cmdAmount}), 32'({1'b1, 16'h0180}));
    rst = 1'b1;
    applyStimulus(6'b0, 1'b0, 1'b1, 16'h0500);
    checkOutput("rst_mid_valid", 32'({cmdValid, mode}), 32'd0);
    checkOutput("rst_clears_flags", 32'({tickOverrun, bcdErr}), 32'd0);
    rst = 1'b0;
    repeat (3) applyStimulus(6'b0, 1'b0, 1'b1, 16'h0500);
    checkOutput("no_accept_after_rst", 32'(cmdValid), 32'd0);

    // Simultaneous presses served in priority order, back to back.
    expQ.push_back({E_ADD, 16'h0300});
    expQ.push_back({E_ADD, 16'h0180});
    expQ.push_back({E_ADD, 16'h0120});
    expQ.push_back({E_ADD, 16'h0060});
    applyStimulus(B_ADD300 | B_ADD180 | B_ADD120 | B_ADD60, 1'b0, 1'b1, 16'h0500);
    applyStimulus(6'b0, 1'b0, 1'b1, 16'h0500);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(6'b0, 1'b0, 1'b1, 16'h0500);
      checkOutput($sformatf("b2b_valid%0d", i), 32'(cmdValid), 32'd1);
    end
    repeat (2) applyStimulus(6'b0, 1'b0, 1'b1, 16'h0500);
    expQ.push_back({E_SET, 16'h0150});
    expQ.push_back({E_SET, 16'h0016});
    expQ.push_back({E_DEC, 16'h0001});
    applyStimulus(B_SET150 | B_SET16, 1'b1, 1'b1, 16'h0500);
    repeat (6) applyStimulus(6'b0, 1'b0, 1'b1, 16'h0500);
    checkOutput("final_idle", 32'(cmdValid), 32'd0);

    checkOutput("scb_empty", 32'(expQ.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", nChecks, nBad);
    $finish;
  end

endmodule
